output_memory_manager: RTL and testbench

Write-back counterpart of the input memory manager. Accepts result groups (one 16-bit element from each of the four quadrant units y0..y3), buffers them in a small group FIFO and serialises them onto the single-port vector memory, one write per cycle. Results land in the output half of memory (address bit 8 = 1), in the same 16x16 row/column layout the input side reads. Pulses layer_done after the 256th element of a layer is written.

---
 rtl/output_memory_manager.sv | 171 +++++++++++++++++
 tb/tb_output_memory_manager.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_memory_manager.sv
`default_nettype none
// ============================================================================
// Module      : output_memory_manager
// Description : Buffers result groups {y3,y2,y1,y0} from the four quadrant
//               units in a small FIFO and serialises them onto the
//               single-port vector memory, one 16-bit write per cycle, into
//               the output half of memory. layer_done pulses once after the
//               256th element of a layer has been written.
//               Optional build macro OUTPUT_RELU_EN: apply ReLU to every
//               element at write time (negative values become zero).
// Revision    : 1.0 - initial release
// ============================================================================
module output_memory_manager #(
  parameter int   FIFO_DEPTH  = 4,
  parameter logic OUTPUT_BASE = 1'b1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        en,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [15:0] y0_element,
  input  logic [15:0] y1_element,
  input  logic [15:0] y2_element,
  input  logic [15:0] y3_element,
  output logic [8:0]  vector_memory_address,
  output logic [15:0] vector_write_element,
  output logic        memory_enable,
  output logic        memory_write,
  output logic        layer_done
);

  localparam int                 c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [63:0]         r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [63:0]         r_hold;
  logic [1:0]          r_q;
  logic [5:0]          r_group;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_write;
  logic [15:0]         w_elem;
  logic [15:0]         w_data;

  // Ready depends only on the registered occupancy, so a full FIFO never
  // accepts even if a pop happens on the same edge.
  assign result_ready = clear_n && en && (r_count < c_DEPTH);
  assign w_push       = result_valid && result_ready;
  assign w_empty      = (r_count == '0);

  // Element for the current quadrant, selected from the held group.
  assign w_elem = r_hold[{r_q, 4'b0000} +: 16];

`ifdef OUTPUT_RELU_EN
  assign w_data = w_elem[15] ? 16'h0000 : w_elem;
`else
  assign w_data = w_elem;
`endif

  // FIFO storage: data only, occupancy is tracked by the pointer block.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {y3_element, y2_element, y1_element, y0_element};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: one write per enabled WRITE cycle, back-to-back pops
  // inside a layer, one bubble cycle in DONE at the end of each layer.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_write      = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          w_write = 1'b1;
          if (r_q == 2'd3) begin
            if (r_group == 6'd63)  w_state_next = S_DONE;
            else if (!w_empty)     w_pop        = 1'b1;
            else                   w_state_next = S_IDLE;
          end
        end
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Holding register, quadrant select and group index within the layer.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_hold  <= '0;
      r_q     <= 2'd0;
      r_group <= 6'd0;
    end else begin
      if (w_pop) r_hold <= r_fifo[r_rd_ptr];
      if (w_write) begin
        r_q <= r_q + 2'd1;
        // 63 + 1 wraps to 0, which starts the next layer at group 0.
        if (r_q == 2'd3) r_group <= r_group + 6'd1;
      end else if (w_pop) begin
        r_q <= 2'd0;
      end
    end
  end

  // Registered memory interface: address is {base, row, col} with
  // row = {q[1], k[5:3]} and col = {q[0], k[2:0]}.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      vector_memory_address <= '0;
      vector_write_element  <= '0;
      memory_enable         <= 1'b0;
      memory_write          <= 1'b0;
      layer_done            <= 1'b0;
    end else begin
      memory_enable <= w_write;
      memory_write  <= w_write;
      layer_done    <= en && (r_state == S_DONE);
      if (w_write) begin
        vector_memory_address <= {OUTPUT_BASE, r_q[1], r_group[5:3], r_q[0], r_group[2:0]};
        vector_write_element  <= w_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_memory_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_memory_manager
// Description : Self-checking bench for output_memory_manager: table-driven
//               single-group vectors, hand-written multi-cycle sequences and
//               a randomized run checked against a write-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_memory_manager;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        en = 1'b1;
  logic        result_valid = 1'b0;
  logic        result_ready;
  logic [15:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0;
  logic [8:0]  addr;
  logic [15:0] wdata;
  logic        men, mwr, ldone;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  output_memory_manager #(.FIFO_DEPTH(4), .OUTPUT_BASE(1'b1)) dut (
    .clock                 (clock),
    .clear_n               (clear_n),
    .en                    (en),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .y0_element            (y0),
    .y1_element            (y1),
    .y2_element            (y2),
    .y3_element            (y3),
    .vector_memory_address (addr),
    .vector_write_element  (wdata),
    .memory_enable         (men),
    .memory_write          (mwr),
    .layer_done            (ldone)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef OUTPUT_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Element q of group k lands at row (q/2)*8 + k/8, column (q%2)*8 + k%8.
  function automatic logic [8:0] addr_of(input int k, input int q);
    int row, col;
    row = (q / 2) * 8 + k / 8;
    col = (q % 2) * 8 + k % 8;
    return 9'(256 + row * 16 + col);
  endfunction

  typedef struct packed { logic [8:0] a; logic [15:0] d; } wr_t;
  wr_t  exp_q[$];
  int   model_groups = 0;
  int   layer_writes = 0;
  bit   pending_done = 1'b0;
  logic prev_en = 1'b0;

  // Monitor at the falling edge: registered outputs are stable, and the
  // inputs seen here are what the next rising edge will use.
  always @(negedge clock) begin : monitor
    wr_t         e;
    int          k;
    logic [15:0] ys [4];
    if (!clear_n) begin
      exp_q.delete();
      model_groups = 0;
      layer_writes = 0;
      pending_done = 1'b0;
      prev_en      = 1'b0;
      chk("reset_outputs", {3'b0, men, mwr, ldone, result_ready, addr, wdata}, 32'h0);
    end else begin
      chk("layer_done", ldone, pending_done && prev_en);
      if (ldone) pending_done = 1'b0;
      chk("write_strobe", mwr, men);
      if (!prev_en) chk("stall_no_write", men, 1'b0);
      if (!en) chk("ready_when_disabled", result_ready, 1'b0);
      if (men) begin
        if (exp_q.size() == 0 || pending_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected at %0t", addr, wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addr, e.a);
          chk("wr_data", wdata, e.d);
          layer_writes++;
          if (layer_writes == 256) begin
            layer_writes = 0;
            pending_done = 1'b1;
          end
        end
      end
      if (result_valid && result_ready) begin
        k  = model_groups % 64;
        ys = '{y0, y1, y2, y3};
        for (int q = 0; q < 4; q++) begin
          e.a = addr_of(k, q);
          e.d = relu(ys[q]);
          exp_q.push_back(e);
        end
        model_groups++;
      end
      prev_en = en;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    result_valid = 1'b0;
    en           = 1'b1;
    clear_n      = 1'b0;
    cyc();
    cyc();
    clear_n = 1'b1;
    cyc();
  endtask

  task automatic set_y(input logic [15:0] a, b, c, d);
    y0 = a; y1 = b; y2 = c; y3 = d;
  endtask

  typedef struct {
    logic [15:0] y [4];
    logic [8:0]  a [4];
    logic [15:0] d [4];
  } vec_t;

  vec_t tbl [3];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int sent, lowseen, nwr, first, last, done_cnt, cycles;
    logic [8:0] last_addr;
    bit acc, after_done, first_after_ok;

    // Table: consecutive groups k = 0, 1, 2 after reset.
    tbl[0].y = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    tbl[0].a = '{9'h100, 9'h108, 9'h180, 9'h188};
    tbl[0].d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    tbl[1].y = '{16'h1234, 16'hABCD, 16'h0042, 16'h7FFF};
    tbl[1].a = '{9'h101, 9'h109, 9'h181, 9'h189};
    tbl[2].y = '{16'hFFF0, 16'h0005, 16'h8000, 16'h7FFF};
    tbl[2].a = '{9'h102, 9'h10A, 9'h182, 9'h18A};
`ifdef OUTPUT_RELU_EN
    tbl[1].d = '{16'h1234, 16'h0000, 16'h0042, 16'h7FFF};
    tbl[2].d = '{16'h0000, 16'h0005, 16'h0000, 16'h7FFF};
`else
    tbl[1].d = '{16'h1234, 16'hABCD, 16'h0042, 16'h7FFF};
    tbl[2].d = '{16'hFFF0, 16'h0005, 16'h8000, 16'h7FFF};
`endif

    do_reset();
    chk("reset_ready_after_release", result_ready, 1'b1);

    // Single groups with exact latency: accept at N, writes after N+2..N+5.
    for (int i = 0; i < 3; i++) begin
      set_y(tbl[i].y[0], tbl[i].y[1], tbl[i].y[2], tbl[i].y[3]);
      result_valid = 1'b1;
      #1;
      chk("tbl_ready", result_ready, 1'b1);
      cyc();
      result_valid = 1'b0;
      chk("tbl_no_write_n", men, 1'b0);
      cyc();
      chk("tbl_no_write_n1", men, 1'b0);
      for (int q = 0; q < 4; q++) begin
        cyc();
        chk("tbl_men", men, 1'b1);
        chk("tbl_addr", addr, tbl[i].a[q]);
        chk("tbl_data", wdata, tbl[i].d[q]);
      end
      cyc();
      chk("tbl_write_ends", men, 1'b0);
      cyc();
    end

    // Six groups with valid held: ready must drop, writes must be gapless.
    sent = 0; lowseen = 0; nwr = 0; first = -1; last = -1;
    set_y(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    for (int c = 0; c < 60; c++) begin
      result_valid = (sent < 6);
      #1;
      acc = result_valid && result_ready;
      if (result_valid && !result_ready) lowseen++;
      cyc();
      if (acc) begin
        sent++;
        set_y(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end
      if (men) begin
        if (first < 0) first = c;
        last = c;
        nwr++;
      end
    end
    result_valid = 1'b0;
    chk("six_groups_sent", sent, 6);
    chk("six_groups_ready_dropped", lowseen > 0, 1'b1);
    chk("six_groups_writes", nwr, 24);
    chk("six_groups_contiguous", last - first + 1, 24);

    // Stall for three cycles after the q1 write; q2/q3 resume in place.
    do_reset();
    set_y(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("stall_q1_addr", addr, 9'h108);
    en = 1'b0;
    #1;
    chk("stall_ready_low", result_ready, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("stall_men_low", men, 1'b0);
    end
    en = 1'b1;
    cyc();
    chk("stall_q2_men", men, 1'b1);
    chk("stall_q2_addr", addr, 9'h180);
    chk("stall_q2_data", wdata, 16'h3333);
    cyc();
    chk("stall_q3_addr", addr, 9'h188);
    chk("stall_q3_data", wdata, 16'h4444);
    cyc();
    cyc();

    // Reset asserted while the q2 write is on the bus.
    do_reset();
    set_y(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("rst_mid_q2_addr", addr, 9'h180);
    clear_n = 1'b0;
    #1;
    chk("rst_mid_outputs_zero", {men, mwr, ldone, result_ready, addr, wdata}, 32'h0);
    cyc();
    cyc();
    clear_n = 1'b1;
    set_y(16'h0009, 16'h0008, 16'h0007, 16'h0006);
    result_valid = 1'b1;
    cyc();
    result_valid = 1'b0;
    cyc();
    cyc();
    chk("rst_after_addr", addr, 9'h100);
    chk("rst_after_data", wdata, 16'h0009);
    chk("rst_after_layer_done", ldone, 1'b0);
    cyc(); cyc(); cyc(); cyc();

    // Full layer of 64 groups plus the first group of the next layer.
    do_reset();
    sent = 0; done_cnt = 0; cycles = 0; last_addr = '0;
    after_done = 1'b0; first_after_ok = 1'b0;
    while (!(first_after_ok && sent == 65) && cycles < 1500) begin
      result_valid = (sent < 65);
      if (sent == 9)       set_y(16'h2A2A, 16'h3B3B, 16'h4C4C, 16'h5D5D);
      else if (sent == 64) set_y(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C);
      else                 set_y(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      #1;
      acc = result_valid && result_ready;
      cyc();
      cycles++;
      if (acc) sent++;
      if (ldone) begin
        done_cnt++;
        after_done = 1'b1;
        chk("layer_last_addr", last_addr, 9'h1FF);
      end
      if (men) begin
        if (addr == 9'h111) chk("layer_k9_q0", wdata, 16'h2A2A);
        if (addr == 9'h199) chk("layer_k9_q3", wdata, 16'h5D5D);
        if (after_done && !first_after_ok) begin
          chk("next_layer_addr", addr, 9'h100);
          chk("next_layer_data", wdata, 16'h0F0F);
          first_after_ok = 1'b1;
        end
        last_addr = addr;
      end
    end
    result_valid = 1'b0;
    chk("layer_stream_finished", first_after_ok, 1'b1);
    chk("layer_done_once", done_cnt, 1);
    for (int c = 0; c < 10; c++) cyc();

    // Randomized traffic with random stalls, checked by the monitor model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en           = ($urandom_range(0, 9) != 0);
      result_valid = $urandom_range(0, 1) == 1;
      set_y(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      cyc();
    end
    en           = 1'b1;
    result_valid = 1'b0;
    for (int c = 0; c < 120; c++) cyc();
    chk("random_drained", exp_q.size(), 0);
    chk("random_no_pending_done", pending_done, 1'b0);
    chk("random_groups_seen", model_groups > 64, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
